// File: rtl/lpc_host_master.sv
// lpc_host_master: LPC I/O read/write initiator driven by a Req/Busy/Done handshake.
// Generates START, CYCTYPE, ADDR, (WDATA), host TAR, SYNC, (RDATA), peripheral TAR.
// Build option: define LPC_ABORT_EN to issue an LFRAME# abort sequence after a SYNC
// timeout; without it a timeout goes straight to DONE with the bus released.
module lpc_host_master #(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned LONG_TIMEOUT = 1024
) (
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [7:0]  WrData,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  RdData,
  output logic [1:0]  ErrCode,
  output logic        LpcFrame,
  output logic [3:0]  LpcBusOut,
  output logic        LpcBusOe,
  input  logic [3:0]  LpcBusIn
);

  localparam int unsigned MaxTimeout = (LONG_TIMEOUT > SYNC_TIMEOUT) ? LONG_TIMEOUT : SYNC_TIMEOUT;
  localparam int unsigned CntW       = $clog2(MaxTimeout + 1);

  localparam logic [CntW-1:0] SyncLimit = CntW'(SYNC_TIMEOUT);
  localparam logic [CntW-1:0] LongLimit = CntW'(LONG_TIMEOUT);

  localparam logic [3:0] SyncReady  = 4'b0000;
  localparam logic [3:0] SyncError  = 4'b1010;
  localparam logic [3:0] SyncLong   = 4'b0110;
  localparam logic [3:0] IdleNibble = 4'b1111;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrSync    = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StCycType,
    StAddr,
    StWData,
    StHTar0,
    StHTar1,
    StSync,
    StRData,
    StPTar0,
    StPTar1,
    StAbort,
    StAbortRel,
    StDone
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [1:0]      nibCnt;
  logic [CntW-1:0] waitCnt;
  logic [CntW-1:0] waitNext;
  logic [CntW-1:0] curLimit;
  logic            longSeen;
  logic            isWrite;
  logic [15:0]     addrReg;
  logic [7:0]      wrDataReg;
  logic            reqAccept;
  logic            syncIsReady;
  logic            syncIsError;
  logic            syncIsLong;
  logic            syncTimeout;

  assign reqAccept   = Req && !Busy;
  assign syncIsReady = (LpcBusIn == SyncReady);
  assign syncIsError = (LpcBusIn == SyncError);
  assign syncIsLong  = (LpcBusIn == SyncLong);
  assign waitNext    = waitCnt + CntW'(1);

  // A long-wait nibble switches to the long limit in the very clock it is seen.
  always_comb begin
    curLimit    = (longSeen || syncIsLong) ? LongLimit : SyncLimit;
    syncTimeout = 1'b0;
    if (state == StSync && !syncIsReady && !syncIsError && waitNext >= curLimit) begin
      syncTimeout = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: one bus clock per phase, multi-nibble phases step on nibCnt.
  always_comb begin
    nextState = state;
    case (state)
      StIdle:     if (reqAccept) nextState = StStart;
      StStart:    nextState = StCycType;
      StCycType:  nextState = StAddr;
      StAddr:     if (nibCnt == 2'd3) nextState = isWrite ? StWData : StHTar0;
      StWData:    if (nibCnt == 2'd1) nextState = StHTar0;
      StHTar0:    nextState = StHTar1;
      StHTar1:    nextState = StSync;
      StSync: begin
        if (syncIsReady || syncIsError) begin
          nextState = isWrite ? StPTar0 : StRData;
        end else if (syncTimeout) begin
`ifdef LPC_ABORT_EN
          nextState = StAbort;
`else
          nextState = StDone;
`endif
        end
      end
      StRData:    if (nibCnt == 2'd1) nextState = StPTar0;
      StPTar0:    nextState = StPTar1;
      StPTar1:    nextState = StDone;
`ifdef LPC_ABORT_EN
      StAbort:    if (nibCnt == 2'd3) nextState = StAbortRel;
      StAbortRel: nextState = StDone;
`endif
      StDone:     nextState = reqAccept ? StStart : StIdle;
      default:    nextState = StIdle;
    endcase
  end

  // Nibble counter restarts on every phase change and steps while a phase repeats.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      nibCnt <= '0;
    end else if (nextState != state) begin
      nibCnt <= '0;
    end else begin
      nibCnt <= nibCnt + 2'd1;
    end
  end

  // Request capture, SYNC wait tracking, error code and read-data capture.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      isWrite   <= 1'b0;
      addrReg   <= '0;
      wrDataReg <= '0;
      waitCnt   <= '0;
      longSeen  <= 1'b0;
      ErrCode   <= ErrOk;
      RdData    <= '0;
    end else begin
      if (reqAccept) begin
        isWrite   <= Write;
        addrReg   <= Addr;
        wrDataReg <= WrData;
        waitCnt   <= '0;
        longSeen  <= 1'b0;
        ErrCode   <= ErrOk;
      end
      if (state == StSync) begin
        if (syncIsError) begin
          ErrCode <= ErrSync;
        end else if (!syncIsReady) begin
          if (syncTimeout) begin
            ErrCode <= ErrTimeout;
            RdData  <= '1;
          end else begin
            waitCnt <= waitNext;
            if (syncIsLong) begin
              longSeen <= 1'b1;
            end
          end
        end
      end
      if (state == StRData) begin
        if (nibCnt[0]) begin
          RdData[7:4] <= LpcBusIn;
        end else begin
          RdData[3:0] <= LpcBusIn;
        end
      end
    end
  end

  // Bus and handshake outputs decoded from the current phase.
  always_comb begin
    LpcFrame  = 1'b1;
    LpcBusOe  = 1'b0;
    LpcBusOut = IdleNibble;
    Busy      = (state != StIdle) && (state != StDone);
    Done      = (state == StDone);
    case (state)
      StStart: begin
        LpcFrame  = 1'b0;
        LpcBusOe  = 1'b1;
        LpcBusOut = 4'b0000;
      end
      StCycType: begin
        LpcBusOe  = 1'b1;
        LpcBusOut = isWrite ? 4'b0010 : 4'b0000;
      end
      StAddr: begin
        LpcBusOe = 1'b1;
        case (nibCnt)
          2'd0:    LpcBusOut = addrReg[15:12];
          2'd1:    LpcBusOut = addrReg[11:8];
          2'd2:    LpcBusOut = addrReg[7:4];
          default: LpcBusOut = addrReg[3:0];
        endcase
      end
      StWData: begin
        LpcBusOe  = 1'b1;
        LpcBusOut = nibCnt[0] ? wrDataReg[7:4] : wrDataReg[3:0];
      end
      StHTar0: begin
        LpcBusOe  = 1'b1;
        LpcBusOut = IdleNibble;
      end
`ifdef LPC_ABORT_EN
      StAbort: begin
        LpcFrame  = 1'b0;
        LpcBusOe  = 1'b1;
        LpcBusOut = IdleNibble;
      end
`endif
      default: begin
        LpcFrame  = 1'b1;
        LpcBusOe  = 1'b0;
        LpcBusOut = IdleNibble;
      end
    endcase
  end

endmodule
